// File: rtl/nn_pkg.sv
// Shared definitions for the neuron feeder: controller states and Q1.15 word width.
package nn_pkg;

  localparam int Q15_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    DRAIN    = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

endpackage

// File: rtl/nn_timeout_ctr.sv
// Down-counter bounding the wait for a neuron result; expired is raised on the
// TIMEOUT-th enabled cycle after a load.
module nn_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Load with TIMEOUT-1 so that the last allowed cycle sees a count of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(TIMEOUT - 1);
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = en && (count == '0);

endmodule

// File: rtl/neuron_feeder.sv
// Streams NUM_INPUTS pixel/weight pairs from synchronous memories into a neuron,
// then waits (bounded) for the neuron result.
module neuron_feeder
  import nn_pkg::*;
#(
  parameter int IN_WIDTH   = Q15_WIDTH,
  parameter int NUM_INPUTS = 784,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  pause,
  input  logic [IN_WIDTH-1:0]   bias_in,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [IN_WIDTH-1:0]   pix_rdata,
  input  logic [IN_WIDTH-1:0]   wgt_rdata,
  output logic [IN_WIDTH-1:0]   data_out,
  output logic [IN_WIDTH-1:0]   weight_out,
  output logic [IN_WIDTH-1:0]   bias_out,
  output logic                  in_valid,
  output logic                  neuron_clr,
  input  logic [IN_WIDTH-1:0]   neuron_result,
  input  logic                  neuron_valid,
  output logic [IN_WIDTH-1:0]   result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [IN_WIDTH-1:0]   bias_q;
  logic [IN_WIDTH-1:0]   result_q;
  logic                  beat;
  logic                  result_pulse;
  logic                  err;
  logic                  rd;
  logic                  clr;
  logic                  tmo_expired;

  // Reads follow pause/abort in the same cycle; abort never issues a read.
  assign rd  = (state == STREAM) && !pause && !abort;
  assign clr = ((state == IDLE) && start) || ((state != IDLE) && abort);

  nn_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (state == DRAIN),
    .en      (state == WAIT_RES),
    .expired (tmo_expired)
  );

  // Controller: state, address counter, bias latch, beat qualifier and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      bias_q       <= '0;
      result_q     <= '0;
      beat         <= 1'b0;
      result_pulse <= 1'b0;
      err          <= 1'b0;
    end else begin
      beat         <= rd;
      result_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            bias_q   <= bias_in;
            err      <= 1'b0;
            addr_cnt <= '0;
          end
        end
        STREAM: begin
          if (abort) begin
            state <= IDLE;
          end else if (rd) begin
            addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
            if (addr_cnt == LAST_ADDR) state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= abort ? IDLE : WAIT_RES;
        end
        WAIT_RES: begin
          if (abort) begin
            state <= IDLE;
          end else if (neuron_valid) begin
            result_q     <= neuron_result;
            result_pulse <= 1'b1;
            state        <= IDLE;
          end else if (tmo_expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is held at zero while reset is asserted, including the reset cycle itself.
  assign mem_rd_en    = rd && !rst;
  assign mem_addr     = rst ? '0 : addr_cnt;
  assign in_valid     = beat && !rst;
  assign data_out     = in_valid ? pix_rdata : '0;
  assign weight_out   = in_valid ? wgt_rdata : '0;
  assign bias_out     = rst ? '0 : bias_q;
  assign neuron_clr   = clr && !rst;
  assign result       = rst ? '0 : result_q;
  assign result_valid = result_pulse && !rst;
  assign busy         = (state != IDLE) && !rst;
  assign error        = err && !rst;

endmodule

// File: tb/tb_neuron_feeder.sv
// Scoreboarded bench: stimulus predicts beats/results from the feeder's rules,
// an independent monitor pops and compares whenever the DUT presents them.
module tb_neuron_feeder;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int AW = 10;

  typedef struct {
    int          cyc;
    logic [15:0] pix;
    logic [15:0] wgt;
    logic [15:0] bias;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } res_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, pause, neuron_valid;
  logic [15:0]   bias_in, neuron_result;
  logic [15:0]   pix_rdata, wgt_rdata;
  logic          mem_rd_en, in_valid, neuron_clr, result_valid, busy, error;
  logic [AW-1:0] mem_addr;
  logic [15:0]   data_out, weight_out, bias_out, result;

  logic [15:0] pix_mem [16];
  logic [15:0] wgt_mem [16];
  beat_t       exp_beats [$];
  res_t        exp_res [$];
  int          cyc = 0;
  int          nchk = 0;
  int          npass = 0;
  logic [15:0] last_res = 16'h0000;

  neuron_feeder #(
    .IN_WIDTH   (16),
    .NUM_INPUTS (N),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (T)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .pause         (pause),
    .bias_in       (bias_in),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .pix_rdata     (pix_rdata),
    .wgt_rdata     (wgt_rdata),
    .data_out      (data_out),
    .weight_out    (weight_out),
    .bias_out      (bias_out),
    .in_valid      (in_valid),
    .neuron_clr    (neuron_clr),
    .neuron_result (neuron_result),
    .neuron_valid  (neuron_valid),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      pix_rdata <= pix_mem[mem_addr[3:0]];
      wgt_rdata <= wgt_mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Monitor: compare every presented beat/result against the head of its queue.
  always @(negedge clk) begin
    if (in_valid) begin
      if (exp_beats.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        beat_t e;
        e = exp_beats.pop_front();
        chk("beat_cycle", cyc, e.cyc);
        chk("beat_data", data_out, e.pix);
        chk("beat_weight", weight_out, e.wgt);
        chk("beat_bias", bias_out, e.bias);
      end
    end
    while (exp_beats.size() > 0 && exp_beats[0].cyc < cyc) begin
      void'(exp_beats.pop_front());
      chk("missing_beat", 32'd0, 32'd1);
    end
    if (result_valid) begin
      if (exp_res.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t r;
        r = exp_res.pop_front();
        chk("result_cycle", cyc, r.cyc);
        chk("result_value", result, r.val);
      end
    end
    while (exp_res.size() > 0 && exp_res[0].cyc < cyc) begin
      void'(exp_res.pop_front());
      chk("missing_result", 32'd0, 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; pause = 1'b0; neuron_valid = 1'b0;
  endtask

  // One evaluation. Phase: 1 streaming (k beats issued), 2 drain, 3 waiting (w cycles), 0 done.
  task automatic run_eval(input logic [15:0] b, input logic [31:0] pmask, input int ppct,
                          input int abort_cyc, input int resp_cyc, input int restart_cyc);
    int k = 0;
    int w = 0;
    int ph = 1;
    bit exp_err = 1'b0;
    bit rd, ab, p;
    idle_inputs();
    start = 1'b1;
    bias_in = b;
    @(negedge clk);
    chk("clr_on_start", neuron_clr, 1'b1);
    chk("busy_at_accept", busy, 1'b0);
    chk("no_read_at_accept", mem_rd_en, 1'b0);
    step();
    for (int rel = 1; ph != 0; rel++) begin
      start = (rel == restart_cyc);
      bias_in = 16'($urandom);
      ab = (rel == abort_cyc);
      p = ((rel < 32) && pmask[rel]) || (int'($urandom_range(99)) < ppct);
      pause = p;
      abort = ab;
      neuron_valid = 1'b0;
      neuron_result = 16'($urandom);
      rd = 1'b0;
      case (ph)
        1: begin
          if (!ab && !p) begin
            rd = 1'b1;
            exp_beats.push_back('{cyc + 1, pix_mem[k], wgt_mem[k], b});
          end
          neuron_valid = ($urandom_range(3) == 0);
        end
        2: neuron_valid = 1'($urandom_range(1));
        3: begin
          w++;
          if (ab) begin
            neuron_valid = 1'b1;
          end else if (w == resp_cyc) begin
            neuron_valid = 1'b1;
            exp_res.push_back('{cyc + 1, neuron_result});
            last_res = neuron_result;
          end
        end
        default: ;
      endcase
      @(negedge clk);
      chk("rd_en", mem_rd_en, rd);
      if (rd) chk("rd_addr", mem_addr, k);
      chk("clr", neuron_clr, ab);
      chk("busy", busy, 1'b1);
      chk("error_cleared", error, 1'b0);
      if (ab) begin
        ph = 0;
      end else begin
        case (ph)
          1: if (rd) begin k++; if (k == N) ph = 2; end
          2: ph = 3;
          3: begin
            if (w == resp_cyc) ph = 0;
            else if (w == T) begin ph = 0; exp_err = 1'b1; end
          end
          default: ph = 0;
        endcase
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("error_after", error, exp_err);
    chk("result_held", result, last_res);
    step();
  endtask

  // Reset asserted in cycle 3 of an evaluation: the read from cycle 2 is discarded.
  task automatic reset_mid(input logic [15:0] b);
    idle_inputs();
    start = 1'b1;
    bias_in = b;
    step();
    start = 1'b0;
    exp_beats.push_back('{cyc + 1, pix_mem[0], wgt_mem[0], b});
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {mem_rd_en, mem_addr, data_out, weight_out, bias_out, in_valid,
                        neuron_clr, result, result_valid, busy, error} == '0, 1'b1);
    step();
    rst = 1'b0;
    last_res = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      pause = 1'($urandom_range(1));
      abort = 1'($urandom_range(1));
      neuron_valid = 1'($urandom_range(1));
      @(negedge clk);
      chk("post_rst_idle", busy, 1'b0);
      chk("post_rst_no_read", mem_rd_en, 1'b0);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bias_in = 16'h0000;
    neuron_result = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      pix_mem[i] = 16'h4000;
      wgt_mem[i] = 16'h2000;
    end
    step();
    @(negedge clk);
    chk("reset_state", {mem_rd_en, mem_addr, data_out, weight_out, bias_out, in_valid,
                        neuron_clr, result, result_valid, busy, error} == '0, 1'b1);
    step();
    rst = 1'b0;
    step();

    run_eval(16'h0100, 32'h0, 0, -1, 2, -1);      // nominal: result at cycle 7
    run_eval(16'h0100, 32'hC, 0, -1, 2, -1);      // pause on cycles 2-3
    run_eval(16'h0100, 32'h0, 0, -1, 2, 3);       // ignored restart
    run_eval(16'h0100, 32'h0, 0, -1, 99, -1);     // timeout
    run_eval(16'h0222, 32'h0, 0, -1, T, -1);      // result on last allowed cycle
    run_eval(16'h0100, 32'h0, 0, 3, 2, -1);       // abort on cycle 3

    abort = 1'b1;
    @(negedge clk);
    chk("abort_in_idle_busy", busy, 1'b0);
    chk("abort_in_idle_clr", neuron_clr, 1'b0);
    step();
    abort = 1'b0;

    reset_mid(16'h0333);

    for (int i = 0; i < 16; i++) begin
      pix_mem[i] = 16'($urandom);
      wgt_mem[i] = 16'($urandom);
    end
    for (int it = 0; it < 12; it++) begin
      run_eval(16'($urandom), 32'h0, int'($urandom_range(50)),
               ($urandom_range(2) == 0) ? int'($urandom_range(1, 14)) : -1,
               int'($urandom_range(1, T + 3)), int'($urandom_range(1, 12)));
    end

    step();
    step();
    chk("beats_all_seen", exp_beats.size(), 32'd0);
    chk("results_all_seen", exp_res.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
